// File: rtl/arb3_rr_burst_if.sv
// rtl/arb3_rr_burst_if.sv - three sink streams and one source stream of the burst arbiter
// The master modport is the arbiter's view; slave is the producer/consumer side.
interface arb3_rr_burst_if #(
  parameter int WORD_BITS = 32
);
  logic [2:0][WORD_BITS-1:0] snk_data;
  logic [2:0]                snk_valid;
  logic [2:0]                snk_ready;
  logic [WORD_BITS-1:0]      src_data;
  logic                      src_valid;
  logic                      src_ready;
  logic [1:0]                src_grant;

  modport master (
    input  snk_data,
    input  snk_valid,
    output snk_ready,
    output src_data,
    output src_valid,
    input  src_ready,
    output src_grant
  );

  modport slave (
    output snk_data,
    output snk_valid,
    input  snk_ready,
    input  src_data,
    input  src_valid,
    output src_ready,
    input  src_grant
  );
endinterface

// File: rtl/arb3_rr_burst.sv
// rtl/arb3_rr_burst.sv - three-input round-robin arbiter with burst lock onto a registered source
// The owner keeps the grant for up to BURST_MAX words; other sinks are scanned from owner+1.
module arb3_rr_burst #(
  parameter int WORD_BITS = 32,
  parameter int BURST_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  arb3_rr_burst_if.master bus
);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_n;
  logic [1:0]         owner, owner_n;
  logic [CNT_W-1:0]   cnt, cnt_n;

  logic               acc;
  logic               win_vld;
  logic [1:0]         win;
  logic [1:0]         cand1, cand2;
  logic               xfer;
  logic [WORD_BITS-1:0] win_data;
  logic               keep_owner;

  assign acc        = !bus.src_valid || bus.src_ready;
  assign cand1      = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
  assign cand2      = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
  assign keep_owner = (state == BURST) && (cnt < CNT_W'(BURST_MAX));

  // Owner is scanned last, so an exhausted burst only continues when nobody else waits.
  always_comb begin
    win_vld = 1'b0;
    win     = owner;
    if (keep_owner && bus.snk_valid[owner]) begin
      win_vld = 1'b1;
      win     = owner;
    end else if (bus.snk_valid[cand1]) begin
      win_vld = 1'b1;
      win     = cand1;
    end else if (bus.snk_valid[cand2]) begin
      win_vld = 1'b1;
      win     = cand2;
    end else if (bus.snk_valid[owner]) begin
      win_vld = 1'b1;
      win     = owner;
    end
  end

  always_comb begin
    win_data = '0;
    case (win)
      2'd0:    win_data = bus.snk_data[0];
      2'd1:    win_data = bus.snk_data[1];
      2'd2:    win_data = bus.snk_data[2];
      default: win_data = '0;
    endcase
  end

  assign xfer          = acc && win_vld && !rst;
  assign bus.snk_ready = xfer ? (3'b001 << win) : 3'b000;

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    if (acc) begin
      if (xfer) begin
        state_n = BURST;
        owner_n = win;
        cnt_n   = (keep_owner && (win == owner)) ? cnt + CNT_W'(1) : CNT_W'(1);
      end else if (state == BURST) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 2'd2;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.src_valid <= 1'b0;
      bus.src_data  <= '0;
      bus.src_grant <= 2'd0;
    end else if (acc) begin
      bus.src_valid <= xfer;
      if (xfer) begin
        bus.src_data  <= win_data;
        bus.src_grant <= win;
      end
    end
  end
endmodule

// File: tb/tb_arb3_rr_burst.sv
// tb/tb_arb3_rr_burst.sv - directed self-checking bench for arb3_rr_burst
// Sink k always offers word {k, n} where n counts its accepted words.
module tb_arb3_rr_burst;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arb3_rr_burst_if #(.WORD_BITS(32)) ifa ();
  arb3_rr_burst_if #(.WORD_BITS(32)) ifb ();

  arb3_rr_burst #(.WORD_BITS(32), .BURST_MAX(4)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa.master)
  );

  arb3_rr_burst #(.WORD_BITS(32), .BURST_MAX(1)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb.master)
  );

  int checks = 0;
  int errors = 0;
  int sa[3];
  int sb[3];
  int g;

  function automatic logic [31:0] word(input int k, input int n);
    return (32'(k) << 16) | 32'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] v, input logic r);
    ifa.snk_valid = v;
    ifa.src_ready = r;
    for (int k = 0; k < 3; k++) ifa.snk_data[k] = word(k, sa[k]);
  endtask

  task automatic drive_b(input logic [2:0] v, input logic r);
    ifb.snk_valid = v;
    ifb.src_ready = r;
    for (int k = 0; k < 3; k++) ifb.snk_data[k] = word(k, sb[k]);
  endtask

  task automatic out_a(input string tag, input int gi, input int n);
    chk({tag, "_valid"}, 32'(ifa.src_valid), 32'd1);
    chk({tag, "_grant"}, 32'(ifa.src_grant), 32'(gi));
    chk({tag, "_data"}, ifa.src_data, word(gi, n));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      sa[k] = 0;
      sb[k] = 0;
    end
    drive_a(3'b111, 1'b1);
    drive_b(3'b000, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(ifa.src_valid), 32'd0);
    chk("rst_data", ifa.src_data, 32'd0);
    chk("rst_grant", 32'(ifa.src_grant), 32'd0);
    chk("rst_ready", 32'(ifa.snk_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // All sinks valid: bursts of four rotating 0,1,2,0
    for (int i = 0; i < 16; i++) begin
      g = (i / 4) % 3;
      drive_a(3'b111, 1'b1);
      #1 chk("all_ready", 32'(ifa.snk_ready), 32'(3'b001 << g));
      tick();
      out_a("all_out", g, sa[g]);
      sa[g]++;
    end

    // Backpressure with owner 0 at cnt==BURST_MAX
    for (int i = 0; i < 5; i++) begin
      drive_a(3'b111, 1'b0);
      #1 chk("bp_ready", 32'(ifa.snk_ready), 32'd0);
      tick();
      out_a("bp_hold", 0, sa[0] - 1);
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(3'b111, 1'b1);
      #1 chk("bp_resume_ready", 32'(ifa.snk_ready), 32'b010);
      tick();
      out_a("bp_resume", 1, sa[1]);
      sa[1]++;
    end
    drive_a(3'b000, 1'b1);
    #1 chk("drain_ready", 32'(ifa.snk_ready), 32'd0);
    tick();
    chk("drain_valid", 32'(ifa.src_valid), 32'd0);

    // Gap: owner 1 kept through IDLE, sink 2 wins, fresh burst of four
    for (int i = 0; i < 2; i++) begin
      drive_a(3'b010, 1'b1);
      #1 chk("gap_ready1", 32'(ifa.snk_ready), 32'b010);
      tick();
      out_a("gap_s1", 1, sa[1]);
      sa[1]++;
    end
    drive_a(3'b000, 1'b1);
    tick();
    chk("gap_idle_valid", 32'(ifa.src_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      g = (i < 4) ? 2 : 1;
      drive_a(3'b110, 1'b1);
      #1 chk("gap_ready", 32'(ifa.snk_ready), 32'(3'b001 << g));
      tick();
      out_a("gap_out", g, sa[g]);
      sa[g]++;
    end

    // Reset mid-burst (owner 1, cnt 2, output valid)
    drive_a(3'b111, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ifa.src_valid), 32'd0);
    chk("mid_rst_ready", 32'(ifa.snk_ready), 32'd0);
    chk("mid_rst_grant", 32'(ifa.src_grant), 32'd0);
    chk("mid_rst_data", ifa.src_data, 32'd0);
    tick();
    rst = 1'b0;
    drive_a(3'b111, 1'b1);
    #1 chk("post_rst_ready", 32'(ifa.snk_ready), 32'b001);
    tick();
    out_a("post_rst", 0, sa[0]);
    sa[0]++;
    drive_a(3'b000, 1'b1);
    tick();

    // BURST_MAX=1: sinks 0 and 2 alternate word by word
    for (int i = 0; i < 8; i++) begin
      g = (i % 2 == 0) ? 0 : 2;
      drive_b(3'b101, 1'b1);
      #1 chk("rr1_ready", 32'(ifb.snk_ready), 32'(3'b001 << g));
      tick();
      chk("rr1_valid", 32'(ifb.src_valid), 32'd1);
      chk("rr1_grant", 32'(ifb.src_grant), 32'(g));
      chk("rr1_data", ifb.src_data, word(g, sb[g]));
      sb[g]++;
    end
    drive_b(3'b000, 1'b1);
    tick();
    chk("rr1_drain", 32'(ifb.src_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
